demux4bit_stream: RTL
=====================

// Module: demux4bit_stream
// PURPOSE
//   Registered 1-to-4 demultiplexer for the ALU datapath: the inverse of the 4:1 operand mux.
//   Routes one WIDTH-bit input word to one of four output lanes, or to all four lanes.
//   Selection uses the same two-bit encoding as the operand mux, sel = {s2,s1}.
//   Every lane has a one-entry output register with a valid/ready handshake.
//   Sits between the ALU result and the four result consumers.
// PARAMETERS
//   WIDTH   4   data word width, in bits
//   CNT_W   8   width of each per-lane delivered-word counter
// PORTS
//   clk        in   1         single clock; all state updates on its rising edge
//   rst_n      in   1         reset, asynchronous, active-low
//   in_data    in   WIDTH     word to route
//   s1         in   1         lane select bit 0
//   s2         in   1         lane select bit 1
//   bcast      in   1         1 = write the word to all four lanes; s1/s2 are ignored
//   in_valid   in   1         in_data, s1, s2 and bcast are valid this cycle
//   in_ready   out  1         block can accept the word this cycle
//   out_data0..3   out  WIDTH   lane 0..3 registered data
//   out_valid  out  4         bit i = lane i holds a word
//   out_ready  in   4         bit i = consumer i takes the word this cycle
//   lane_cnt0..3   out  CNT_W   words delivered on lane 0..3
//   busy       out  1         OR of out_valid
// BEHAVIOUR
//   Reset (rst_n=0, takes effect at once with no clock)
//     - out_valid=0, all out_data=0, all lane_cnt=0, busy=0.
//     - A word held in any lane is discarded.
//     - in_ready=0 while rst_n=0. In the first cycle after release, in_ready=1.
//   Lane state machine (per lane): EMPTY <-> FULL, with FULL == out_valid[i].
//     - EMPTY -> FULL when a write to lane i is accepted.
//     - FULL -> EMPTY when out_ready[i]=1 and no new write to lane i is accepted.
//     - FULL -> FULL when out_ready[i]=1 and a new write is accepted in the same cycle.
//       This is a pass-through: no bubble, and the new word replaces the old one.
//   Lane free: free[i] = ~out_valid[i] | out_ready[i].
//   in_ready (combinational)
//     - bcast=0: in_ready = free[sel].
//     - bcast=1: in_ready = &free (all four lanes must be free).
//     - in_ready does not depend on in_valid.
//   Accept: in_valid & in_ready at a rising edge of clk.
//     - The word appears on the target lane(s) at the next edge: latency 1 cycle.
//     - Non-target lanes are unchanged.
//     - If the source holds in_valid while in_ready=0, nothing is written.
//   out_data[i]
//     - Changes only on an accepted write to lane i.
//     - Holds its value after the word is drained; out_valid qualifies it.
//   lane_cnt[i]
//     - Increments by 1 on each cycle with out_valid[i] & out_ready[i].
//     - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
//   Throughput
//     - With every consumer ready, one word per cycle for any sel sequence,
//       including back-to-back words to the same lane.
//   Boundary cases
//     - sel changes while in_valid=0 has no effect.
//     - If lane 2 is full and stalled, a word for lane 1 is still accepted.
//       There is no head-of-line blocking beyond the current word.
//     - bcast while one lane is stalled: in_ready=0 and no lane is written.
//     - Reset asserted mid-handshake: the word is dropped and lane_cnt is not incremented.
// TESTING
//   1. Reset release, then in_data=4'hA, s2s1=2'b10, in_valid=1 for 1 cycle
//      -> next cycle out_valid=4'b0100, out_data2=4'hA; other lanes stay 0.
//   2. out_ready=4'hF, stream 4'h1,4'h2,4'h3,4'h4 with sel 0,1,2,3 on consecutive cycles
//      -> in_ready=1 throughout; each lane_cntN=1 after the last word; no bubbles.
//   3. Lane 3 full with out_ready[3]=0; offer 4'h5 to lane 3, then 4'h6 to lane 0
//      -> in_ready=0 for 4'h5; out_data3 keeps its old value; after switching sel to 0,
//         4'h6 is accepted and lands in lane 0.
//   4. Lane 3 full with out_ready[3]=1, new word 4'h7 to lane 3 in the same cycle
//      -> out_valid[3] stays 1; out_data3=4'h7 next cycle; lane_cnt3 increments by 1.
//   5. bcast=1 with in_data=4'hC while lane 1 is stalled -> in_ready=0;
//      release lane 1 -> all four lanes get 4'hC the next cycle; out_valid=4'hF.
//   6. Drive 256 handshakes on lane 0 -> lane_cnt0 wraps to 0.
//      Assert rst_n=0 mid-stream -> out_valid=0 and busy=0 immediately, with no clock edge.

Source files
------------

// File: rtl/demux4bit_stream.sv
// demux4bit_stream: registered 1-to-4 demultiplexer for the ALU result path.
// It routes one input word to one lane, or to all four lanes when bcast is set.
// Each lane is a one-entry output register with a valid/ready handshake.
// A lane that is full and being drained this cycle counts as free. A new word
// can therefore pass straight through without a bubble.
module demux4bit_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s1,
    input  logic             s2,
    input  logic             bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] lane_cnt0,
    output logic [CNT_W-1:0] lane_cnt1,
    output logic [CNT_W-1:0] lane_cnt2,
    output logic [CNT_W-1:0] lane_cnt3,
    output logic             busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_e;

    lane_state_e      state_q [4];
    lane_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

    logic [1:0] sel;
    logic [3:0] free;
    logic [3:0] deliver;
    logic [3:0] write_en;
    logic       accept;

    // Handshake decode: lane free flags, in_ready (held low in reset), accept and per-lane write enables
    always_comb begin
        sel      = {s2, s1};
        free     = '0;
        deliver  = '0;
        write_en = '0;
        for (int i = 0; i < 4; i++) begin
            free[i]    = (state_q[i] == EMPTY) | out_ready[i];
            deliver[i] = (state_q[i] == FULL) & out_ready[i];
        end
        if (bcast) begin
            in_ready = rst_n & (&free);
        end else begin
            in_ready = rst_n & free[sel];
        end
        accept = in_valid & in_ready;
        for (int i = 0; i < 4; i++) begin
            write_en[i] = accept & (bcast | (sel == 2'(i)));
        end
    end

    // Per-lane next state, data and delivered-word counter
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (write_en[i]) begin
                        state_d[i] = FULL;
                    end
                end
                FULL: begin
                    if (out_ready[i] && !write_en[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
                default: state_d[i] = EMPTY;
            endcase
            if (write_en[i]) begin
                data_d[i] = in_data;
            end
            if (deliver[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Lane registers; reset discards any held word and clears the counters immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output mapping from lane registers
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
        busy      = (state_q[0] == FULL) | (state_q[1] == FULL) |
                    (state_q[2] == FULL) | (state_q[3] == FULL);
        out_data0 = data_q[0];
        out_data1 = data_q[1];
        out_data2 = data_q[2];
        out_data3 = data_q[3];
        lane_cnt0 = cnt_q[0];
        lane_cnt1 = cnt_q[1];
        lane_cnt2 = cnt_q[2];
        lane_cnt3 = cnt_q[3];
    end

endmodule
